addsub_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational WIDTH-bit ripple adder-subtractor between two independent requesters. Each requester presents operands and an add/subtract select with a valid/ready handshake. The block grants one request at a time, latches its operands, drives the shared datapath, and returns a registered result tagged with the requester ID. Only one operation is in flight, and the result is held until the consumer accepts it.

---
 rtl/addsub_arbiter_if.sv | 48 ++++
 rtl/addsub_arbiter.sv | 118 +++++++++++
 tb/tb_addsub_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Handshake bundle between two requesters, one consumer and addsub_arbiter.
// master: requesters/consumer side; slave: arbiter side. rsp_ovf only with ADDSUB_ARB_OVF_EN.
interface addsub_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sel;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sel;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
`ifdef ADDSUB_ARB_OVF_EN
    logic             rsp_ovf;
`endif

    modport master (
`ifdef ADDSUB_ARB_OVF_EN
        input  rsp_ovf,
`endif
        output req0_valid, req0_a, req0_b, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready
    );

    modport slave (
`ifdef ADDSUB_ARB_OVF_EN
        output rsp_ovf,
`endif
        input  req0_valid, req0_a, req0_b, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one add/sub datapath between two requesters.
// Ports: clk, rst (sync, active-high), bus (addsub_arbiter_if.slave).
// Optional macro ADDSUB_ARB_OVF_EN adds the signed-overflow result bit.
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    addsub_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             last;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sel;
    logic             op_id;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             id_q;
`ifdef ADDSUB_ARB_OVF_EN
    logic [WIDTH-1:0] low;
    logic             ovf_q;
`endif

    // Grant only in IDLE and never in a reset cycle; on contention
    // the requester not served last wins.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!rst) begin
                    gnt0 = bus.req0_valid
                         && (!bus.req1_valid || last);
                    gnt1 = bus.req1_valid
                         && (!bus.req0_valid || !last);
                end
                if (gnt0 || gnt1)
                    state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Subtract is a + ~b + 1, with sel doubling as carry-in.
    always_comb begin
        bx   = op_b ^ {WIDTH{op_sel}};
        full = {1'b0, op_a} + {1'b0, bx}
             + {{WIDTH{1'b0}}, op_sel};
    end

`ifdef ADDSUB_ARB_OVF_EN
    // Carry into the MSB comes from the lower WIDTH-1 bits.
    always_comb begin
        low = {1'b0, op_a[WIDTH-2:0]}
            + {1'b0, bx[WIDTH-2:0]}
            + {{(WIDTH-1){1'b0}}, op_sel};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= 1'b0;
            op_id  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            id_q   <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (gnt0 || gnt1) begin
                op_a   <= gnt1 ? bus.req1_a : bus.req0_a;
                op_b   <= gnt1 ? bus.req1_b : bus.req0_b;
                op_sel <= gnt1 ? bus.req1_sel : bus.req0_sel;
                op_id  <= gnt1;
                last   <= gnt1;
            end
            if (state == EXEC) begin
                sum_q  <= full[WIDTH-1:0];
                cout_q <= full[WIDTH];
                id_q   <= op_id;
`ifdef ADDSUB_ARB_OVF_EN
                ovf_q  <= low[WIDTH-1] ^ full[WIDTH];
`endif
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_cout   = cout_q;
`ifdef ADDSUB_ARB_OVF_EN
    assign bus.rsp_ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized bench for addsub_arbiter against a transaction-level model.
// Checks grants, response timing, results and reset behaviour.
module tb_addsub_arbiter;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    addsub_arbiter_if #(.WIDTH(W)) bus ();

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit busy     = 1'b0;
    int age      = 0;
    bit last     = 1'b1;
    bit rst_prev = 1'b1;
    int x_id, x_sum, x_cout, x_ovf;
    bit fired0, fired1;

    // directed operations first: a, b, sel triples
    int q0[$] = '{9, 8, 0, 7, 1, 0};
    int q1[$] = '{3, 5, 1, 5, 3, 1};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    task automatic compute(input int a, input int b,
                           input bit sel);
        int r;
        int rs;
        r  = sel ? (a - b + M) : (a + b);
        rs = sel ? (sgn(a) - sgn(b)) : (sgn(a) + sgn(b));
        x_sum  = r % M;
        x_cout = sel ? int'(a >= b) : int'(a + b >= M);
        x_ovf  = int'(rs < -M / 2 || rs >= M / 2);
    endtask

    task automatic load0();
        if (q0.size() >= 3) begin
            bus.req0_a   = W'(q0.pop_front());
            bus.req0_b   = W'(q0.pop_front());
            bus.req0_sel = q0.pop_front() != 0;
        end else begin
            bus.req0_a   = W'($urandom_range(M - 1));
            bus.req0_b   = W'($urandom_range(M - 1));
            bus.req0_sel = $urandom_range(1) != 0;
        end
    endtask

    task automatic load1();
        if (q1.size() >= 3) begin
            bus.req1_a   = W'(q1.pop_front());
            bus.req1_b   = W'(q1.pop_front());
            bus.req1_sel = q1.pop_front() != 0;
        end else begin
            bus.req1_a   = W'($urandom_range(M - 1));
            bus.req1_b   = W'($urandom_range(M - 1));
            bus.req1_sel = $urandom_range(1) != 0;
        end
    endtask

    // One clock: drive just after the edge, check on the falling
    // edge, then advance the model for the coming rising edge.
    task automatic cycle(input bit r, input int pv, input int pr);
        bit e0, e1, erv, rr;
        rst = r;
        bus.rsp_ready = ($urandom_range(99) < pr);
        if (fired0) bus.req0_valid = 1'b0;
        if (fired1) bus.req1_valid = 1'b0;
        if (!bus.req0_valid && $urandom_range(99) < pv) begin
            bus.req0_valid = 1'b1;
            load0();
        end
        if (!bus.req1_valid && $urandom_range(99) < pv) begin
            bus.req1_valid = 1'b1;
            load1();
        end
        fired0 = 1'b0;
        fired1 = 1'b0;

        @(negedge clk);
        e0  = !r && !busy && bus.req0_valid
            && (!bus.req1_valid || last);
        e1  = !r && !busy && bus.req1_valid
            && (!bus.req0_valid || !last);
        erv = busy && age >= 2;
        rr  = bus.rsp_ready;
        check("rdy0", bus.req0_ready, e0);
        check("rdy1", bus.req1_ready, e1);
        check("both_rdy", bus.req0_ready & bus.req1_ready, 0);
        check("rsp_valid", bus.rsp_valid, erv);
        if (erv) begin
            check("rsp_id", bus.rsp_id, x_id);
            check("rsp_sum", bus.rsp_sum, x_sum);
            check("rsp_cout", bus.rsp_cout, x_cout);
`ifdef ADDSUB_ARB_OVF_EN
            check("rsp_ovf", bus.rsp_ovf, x_ovf);
`endif
        end
        if (rst_prev) begin
            check("rst_id", bus.rsp_id, 0);
            check("rst_sum", bus.rsp_sum, 0);
            check("rst_cout", bus.rsp_cout, 0);
`ifdef ADDSUB_ARB_OVF_EN
            check("rst_ovf", bus.rsp_ovf, 0);
`endif
        end

        if (r) begin
            busy = 1'b0;
            last = 1'b1;
        end else if (busy) begin
            if (age >= 2 && rr) busy = 1'b0;
            else if (age < 2) age++;
        end else if (e0 || e1) begin
            busy   = 1'b1;
            age    = 1;
            x_id   = int'(e1);
            last   = e1;
            fired0 = e0;
            fired1 = e1;
            if (e1) compute(bus.req1_a, bus.req1_b, bus.req1_sel);
            else    compute(bus.req0_a, bus.req0_b, bus.req0_sel);
        end
        rst_prev = r;

        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_sel   = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_sel   = 1'b0;
        bus.rsp_ready  = 1'b0;
        fired0 = 1'b0;
        fired1 = 1'b0;
        @(posedge clk);
        #1;

        // reset held with requests pending
        cycle(1, 100, 100);
        cycle(1, 100, 100);

        // contention: both always valid, consumer always ready
        for (int i = 0; i < 30; i++) cycle(0, 100, 100);

        // backpressure: 5 cycles without rsp_ready in RESP
        k = 0;
        while (!(busy && age >= 2) && k < 20) begin
            cycle(0, 50, 0);
            k++;
        end
        check("bp_reach", int'(busy && age >= 2), 1);
        for (int i = 0; i < 5; i++) cycle(0, 100, 0);
        for (int i = 0; i < 6; i++) cycle(0, 100, 100);

        // reset while in EXEC
        k = 0;
        while (!(busy && age == 1) && k < 20) begin
            cycle(0, 100, 100);
            k++;
        end
        check("exec_reach", int'(busy && age == 1), 1);
        cycle(1, 100, 100);
        for (int i = 0; i < 12; i++) cycle(0, 100, 100);

        // random traffic
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(99) < 2, 40, 60);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
